// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage: register bank with write-first bypass, load-use hazard detection
// and a registered ID/EX slot with valid/ready handshake toward IF/ID and EX.
module id_stage_pipelined #(
  parameter int unsigned REGISTER_BANK_SIZE = 32,
  parameter int unsigned BUS_SIZE           = 32,
  parameter int unsigned PC_SIZE            = 32,
  parameter int unsigned CTRL_SIZE          = 17,
  parameter int unsigned STALL_CNT_WIDTH    = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset_n,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [BUS_SIZE-1:0]                    i_instruction,
  input  logic [PC_SIZE-1:0]                     i_next_seq_pc,
  input  logic [CTRL_SIZE-1:0]                   i_ctrl_word,
  input  logic                                   i_flush,
  input  logic                                   i_ex_ready,
  input  logic                                   i_wb_en,
  input  logic [$clog2(REGISTER_BANK_SIZE)-1:0]  i_wb_addr,
  input  logic [BUS_SIZE-1:0]                    i_wb_data,
  output logic                                   o_valid,
  output logic [BUS_SIZE-1:0]                    o_bus_A,
  output logic [BUS_SIZE-1:0]                    o_bus_B,
  output logic [4:0]                             o_rs,
  output logic [4:0]                             o_rt,
  output logic [4:0]                             o_rd,
  output logic [BUS_SIZE-1:0]                    o_shamt_ext,
  output logic [BUS_SIZE-1:0]                    o_inm_ext_signed,
  output logic [CTRL_SIZE-1:0]                   o_ctrl,
  output logic [PC_SIZE-1:0]                     o_next_seq_pc,
  output logic [STALL_CNT_WIDTH-1:0]             o_stall_count,
  output logic [REGISTER_BANK_SIZE*BUS_SIZE-1:0] o_bus_debug
);

  logic [BUS_SIZE-1:0] bank [REGISTER_BANK_SIZE];

  logic [4:0]          id_rs, id_rt, id_rd, id_shamt;
  logic [15:0]         id_imm;
  logic [BUS_SIZE-1:0] rd_a, rd_b;
  logic [4:0]          ex_dst;
  logic                hazard, advance;
  logic                unused_opcode;

  assign id_rs         = i_instruction[25:21];
  assign id_rt         = i_instruction[20:16];
  assign id_rd         = i_instruction[15:11];
  assign id_shamt      = i_instruction[10:6];
  assign id_imm        = i_instruction[15:0];
  assign unused_opcode = ^i_instruction[BUS_SIZE-1:26];

  // Register 0 is never written, so its reset value keeps it reading as zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < REGISTER_BANK_SIZE; i++) bank[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      bank[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    o_bus_debug = '0;
    for (int unsigned i = 0; i < REGISTER_BANK_SIZE; i++)
      o_bus_debug[i*BUS_SIZE +: BUS_SIZE] = bank[i];
  end

  // Write-first: a same-cycle write-back to the addressed register wins over the stored value.
  assign rd_a = (id_rs == '0) ? '0 :
                (i_wb_en && (i_wb_addr == id_rs)) ? i_wb_data : bank[id_rs];
  assign rd_b = (id_rt == '0) ? '0 :
                (i_wb_en && (i_wb_addr == id_rt)) ? i_wb_data : bank[id_rt];

  always_comb begin
    ex_dst = '0;
    case (o_ctrl[CTRL_SIZE-1 -: 2])
      2'b00:   ex_dst = o_rt;
      2'b01:   ex_dst = o_rd;
      2'b10:   ex_dst = 5'd31;
      default: ex_dst = '0;
    endcase
  end

  assign hazard  = o_valid && o_ctrl[0] && o_ctrl[1] && (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (ex_dst == id_rt));
  assign advance = !o_valid || i_ex_ready;
  assign o_ready = advance && !hazard && !i_flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid          <= 1'b0;
      o_bus_A          <= '0;
      o_bus_B          <= '0;
      o_rs             <= '0;
      o_rt             <= '0;
      o_rd             <= '0;
      o_shamt_ext      <= '0;
      o_inm_ext_signed <= '0;
      o_ctrl           <= '0;
      o_next_seq_pc    <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (advance) begin
      if (i_valid && !hazard) begin
        o_valid          <= 1'b1;
        o_bus_A          <= rd_a;
        o_bus_B          <= rd_b;
        o_rs             <= id_rs;
        o_rt             <= id_rt;
        o_rd             <= id_rd;
        o_shamt_ext      <= {{(BUS_SIZE-5){1'b0}}, id_shamt};
        o_inm_ext_signed <= {{(BUS_SIZE-16){id_imm[15]}}, id_imm};
        o_ctrl           <= i_ctrl_word;
        o_next_seq_pc    <= i_next_seq_pc;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_count <= '0;
    end else if (i_valid && hazard && !i_flush && (o_stall_count != '1)) begin
      o_stall_count <= o_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed vector table, hand-built stall/reset sequences,
// then randomized traffic against a behavioural model of the decode stage.
module tb_id_stage_pipelined;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_flush, i_ex_ready, i_wb_en;
  logic [31:0]   i_instruction, i_next_seq_pc, i_wb_data;
  logic [16:0]   i_ctrl_word;
  logic [4:0]    i_wb_addr;

  logic          o_ready, o_valid;
  logic [31:0]   o_bus_A, o_bus_B, o_shamt_ext, o_inm_ext_signed, o_next_seq_pc;
  logic [4:0]    o_rs, o_rt, o_rd;
  logic [16:0]   o_ctrl;
  logic [15:0]   o_stall_count;
  logic [1023:0] o_bus_debug;

  logic          d2_ready, d2_valid;
  logic [31:0]   d2_a, d2_b, d2_shamt, d2_imm, d2_pc;
  logic [4:0]    d2_rs, d2_rt, d2_rd;
  logic [16:0]   d2_ctrl;
  logic [1:0]    d2_stall;
  logic [1023:0] d2_debug;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage_pipelined dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_next_seq_pc(i_next_seq_pc), .i_ctrl_word(i_ctrl_word),
    .i_flush(i_flush), .i_ex_ready(i_ex_ready), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data), .o_valid(o_valid), .o_bus_A(o_bus_A), .o_bus_B(o_bus_B),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt_ext(o_shamt_ext),
    .o_inm_ext_signed(o_inm_ext_signed), .o_ctrl(o_ctrl), .o_next_seq_pc(o_next_seq_pc),
    .o_stall_count(o_stall_count), .o_bus_debug(o_bus_debug)
  );

  id_stage_pipelined #(.STALL_CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(d2_ready),
    .i_instruction(i_instruction), .i_next_seq_pc(i_next_seq_pc), .i_ctrl_word(i_ctrl_word),
    .i_flush(i_flush), .i_ex_ready(i_ex_ready), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data), .o_valid(d2_valid), .o_bus_A(d2_a), .o_bus_B(d2_b),
    .o_rs(d2_rs), .o_rt(d2_rt), .o_rd(d2_rd), .o_shamt_ext(d2_shamt),
    .o_inm_ext_signed(d2_imm), .o_ctrl(d2_ctrl), .o_next_seq_pc(d2_pc),
    .o_stall_count(d2_stall), .o_bus_debug(d2_debug)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    logic [4:0] s, t, d;
    s = 5'(rs); t = 5'(rt); d = 5'(rd);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [16:0] ctl,
                       input logic fl, input logic exr, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    i_valid = v; i_instruction = ins; i_ctrl_word = ctl; i_flush = fl;
    i_ex_ready = exr; i_wb_en = we; i_wb_addr = wa; i_wb_data = wd;
    i_next_seq_pc = i_next_seq_pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [16:0] ctrl;
    logic        flush, ex_ready, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_ready, exp_valid;
    logic [31:0] exp_a, exp_b;
    logic [15:0] exp_stall;
  } vec_t;

  localparam logic [16:0] CTRL_ALU = 17'h08002;  // reg_dst=rd, wb, no mem_to_reg
  localparam logic [16:0] CTRL_LW  = 17'h00003;  // reg_dst=rt, wb, mem_to_reg

  typedef struct {
    logic        valid;
    logic [31:0] a, b, shamt, imm, pc;
    logic [4:0]  rs, rt, rd;
    logic [16:0] ctrl;
  } slot_t;

  logic [31:0] mreg [32];
  slot_t       ms;
  int          mcnt;

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (i_wb_en && i_wb_addr == r) return i_wb_data;
    return mreg[r];
  endfunction

  function automatic logic model_hazard();
    int dst;
    logic [4:0] rs, rt;
    rs = i_instruction[25:21];
    rt = i_instruction[20:16];
    case (int'(ms.ctrl[16:15]))
      0: dst = int'(ms.rt);
      1: dst = int'(ms.rd);
      2: dst = 31;
      default: dst = 0;
    endcase
    return ms.valid && ms.ctrl[0] && ms.ctrl[1] && dst != 0 &&
           (dst == int'(rs) || dst == int'(rt));
  endfunction

  vec_t vec [11];
  logic [31:0] tmp;

  initial begin
    rst_n = 1'b0;
    i_next_seq_pc = 32'h0000_1000;
    drive(0, 32'd0, 17'd0, 0, 1, 0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_stall", {48'd0, o_stall_count}, 64'd0);
    chk("reset_bus_A", {32'd0, o_bus_A}, 64'd0);
    chk("reset_debug_nz", {63'd0, |o_bus_debug}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // valid instr ctrl flush exr wb_en wb_addr wb_data | ready valid A B stall
    vec[0]  = '{1, rtype(5,0,1), CTRL_ALU, 0, 1, 1, 5'd5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'h0, 16'd0};
    vec[1]  = '{1, rtype(2,3,0), CTRL_LW,  0, 1, 1, 5'd2, 32'h00000100, 1, 1, 32'h100, 32'h0, 16'd0};
    vec[2]  = '{1, rtype(3,2,4), CTRL_ALU, 0, 1, 0, 5'd0, 32'h0,        0, 0, 32'h0, 32'h0, 16'd1};
    vec[3]  = '{1, rtype(3,2,4), CTRL_ALU, 0, 1, 1, 5'd3, 32'h00000055, 1, 1, 32'h55, 32'h100, 16'd1};
    vec[4]  = '{1, rtype(1,5,6), CTRL_ALU, 0, 0, 0, 5'd0, 32'h0,        0, 1, 32'h55, 32'h100, 16'd1};
    vec[5]  = '{1, rtype(1,5,6), CTRL_ALU, 0, 0, 0, 5'd0, 32'h0,        0, 1, 32'h55, 32'h100, 16'd1};
    vec[6]  = '{1, rtype(1,5,6), CTRL_ALU, 0, 0, 0, 5'd0, 32'h0,        0, 1, 32'h55, 32'h100, 16'd1};
    vec[7]  = '{1, rtype(1,5,6), CTRL_ALU, 0, 1, 0, 5'd0, 32'h0,        1, 1, 32'h0, 32'hDEADBEEF, 16'd1};
    vec[8]  = '{1, rtype(5,5,7), CTRL_ALU, 1, 1, 0, 5'd0, 32'h0,        0, 0, 32'h0, 32'h0, 16'd1};
    vec[9]  = '{1, rtype(0,0,8), CTRL_ALU, 0, 1, 1, 5'd0, 32'h00000001, 1, 1, 32'h0, 32'h0, 16'd1};
    vec[10] = '{0, 32'd0,        CTRL_ALU, 0, 1, 0, 5'd0, 32'h0,        1, 0, 32'h0, 32'h0, 16'd1};

    for (int k = 0; k < 11; k++) begin
      drive(vec[k].valid, vec[k].instr, vec[k].ctrl, vec[k].flush, vec[k].ex_ready,
            vec[k].wb_en, vec[k].wb_addr, vec[k].wb_data);
      #1;
      chk($sformatf("vec%0d_ready", k), {63'd0, o_ready}, {63'd0, vec[k].exp_ready});
      tick();
      chk($sformatf("vec%0d_valid", k), {63'd0, o_valid}, {63'd0, vec[k].exp_valid});
      chk($sformatf("vec%0d_stall", k), {48'd0, o_stall_count}, {48'd0, vec[k].exp_stall});
      if (vec[k].exp_valid) begin
        chk($sformatf("vec%0d_A", k), {32'd0, o_bus_A}, {32'd0, vec[k].exp_a});
        chk($sformatf("vec%0d_B", k), {32'd0, o_bus_B}, {32'd0, vec[k].exp_b});
      end
    end
    chk("debug_r0", {32'd0, o_bus_debug[31:0]}, 64'd0);
    chk("debug_r2", {32'd0, o_bus_debug[2*32 +: 32]}, 64'h100);
    chk("debug_r3", {32'd0, o_bus_debug[3*32 +: 32]}, 64'h55);
    chk("debug_r5", {32'd0, o_bus_debug[5*32 +: 32]}, 64'hDEADBEEF);

    // Load held in ID/EX under backpressure: dependent instruction stalls every cycle.
    drive(1, rtype(2,3,0), CTRL_LW, 0, 1, 0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, rtype(3,2,4), CTRL_ALU, 0, 0, 0, 5'd0, 32'd0);
      #1;
      chk("sat_ready", {63'd0, o_ready}, 64'd0);
      tick();
    end
    chk("sat_hold_valid", {63'd0, o_valid}, 64'd1);
    chk("sat_hold_A", {32'd0, o_bus_A}, 64'h100);
    chk("sat_hold_rt", {59'd0, o_rt}, 64'd3);
    chk("sat_count16", {48'd0, o_stall_count}, 64'd6);
    chk("sat_count2", {62'd0, d2_stall}, 64'd3);
    drive(1, rtype(3,2,4), CTRL_ALU, 0, 1, 0, 5'd0, 32'd0);
    tick();
    chk("sat_bubble_valid", {63'd0, o_valid}, 64'd0);
    chk("sat_bubble_count", {48'd0, o_stall_count}, 64'd7);
    tick();
    chk("sat_after_valid", {63'd0, o_valid}, 64'd1);
    chk("sat_after_A", {32'd0, o_bus_A}, 64'h55);
    chk("sat_after_B", {32'd0, o_bus_B}, 64'h100);

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {63'd0, o_valid}, 64'd0);
    chk("areset_stall", {48'd0, o_stall_count}, 64'd0);
    chk("areset_stall2", {62'd0, d2_stall}, 64'd0);
    chk("areset_debug_nz", {63'd0, |o_bus_debug}, 64'd0);
    drive(0, 32'd0, 17'd0, 0, 1, 0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    ms = '{valid: 1'b0, default: '0};
    mcnt = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [4:0]  rs, rt, rd;
      logic [16:0] ctl;
      logic        haz, adv, rdy;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      tmp = $urandom;
      ctl = 17'($urandom);
      if ($urandom_range(0, 1) == 1) ctl[1:0] = 2'b11;
      drive($urandom_range(0, 3) != 0, {tmp[31:26], rs, rt, rd, tmp[10:0]}, ctl,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      #1;
      haz = model_hazard();
      adv = !ms.valid || i_ex_ready;
      rdy = adv && !haz && !i_flush;
      chk("rand_ready", {63'd0, o_ready}, {63'd0, rdy});
      tick();
      if (i_valid && haz && !i_flush) mcnt++;
      if (i_flush) ms.valid = 1'b0;
      else if (adv) begin
        if (i_valid && !haz) begin
          ms.valid = 1'b1;
          ms.a     = mread(rs);
          ms.b     = mread(rt);
          ms.rs    = rs;
          ms.rt    = rt;
          ms.rd    = rd;
          ms.shamt = 32'(i_instruction[10:6]);
          ms.imm   = 32'(int'($signed(i_instruction[15:0])));
          ms.ctrl  = i_ctrl_word;
          ms.pc    = i_next_seq_pc;
        end else ms.valid = 1'b0;
      end
      if (i_wb_en && i_wb_addr != 0) mreg[i_wb_addr] = i_wb_data;

      chk("rand_valid", {63'd0, o_valid}, {63'd0, ms.valid});
      chk("rand_stall", {48'd0, o_stall_count}, 64'(mcnt > 65535 ? 65535 : mcnt));
      chk("rand_stall2", {62'd0, d2_stall}, 64'(mcnt > 3 ? 3 : mcnt));
      if (ms.valid) begin
        chk("rand_A", {32'd0, o_bus_A}, {32'd0, ms.a});
        chk("rand_B", {32'd0, o_bus_B}, {32'd0, ms.b});
        chk("rand_fields", {49'd0, o_rs, o_rt, o_rd}, {49'd0, ms.rs, ms.rt, ms.rd});
        chk("rand_shamt", {32'd0, o_shamt_ext}, {32'd0, ms.shamt});
        chk("rand_imm", {32'd0, o_inm_ext_signed}, {32'd0, ms.imm});
        chk("rand_ctrl", {47'd0, o_ctrl}, {47'd0, ms.ctrl});
        chk("rand_pc", {32'd0, o_next_seq_pc}, {32'd0, ms.pc});
      end
      if (cyc % 64 == 0) begin
        for (int r = 0; r < 32; r++)
          chk($sformatf("rand_debug_r%0d", r), {32'd0, o_bus_debug[r*32 +: 32]}, {32'd0, mreg[r]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
